// File: rtl/pc_unit_ras.sv
// Fetch-stage program counter with a circular return-address stack.
// Next-PC priority is Ret > Call > Jump > Branch > sequential; ras_ovf and ras_unf are sticky error flags.
module pc_unit_ras #(
  parameter int unsigned       ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0,
  parameter int unsigned       INC       = 4,
  parameter int unsigned       RAS_DEPTH = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              pc_ld_en_i,
  input  logic              branch_i,
  input  logic [ADDR_W-1:0] br_offset_i,
  input  logic              jump_i,
  input  logic              call_i,
  input  logic              ret_i,
  input  logic [ADDR_W-1:0] jump_addr_i,
  input  logic              flag_clr_i,
  output logic [ADDR_W-1:0] curr_addr_o,
  output logic [ADDR_W-1:0] seq_addr_o,
  output logic              ras_empty_o,
  output logic              ras_full_o,
  output logic              ras_ovf_o,
  output logic              ras_unf_o
);

  localparam int unsigned       PTR_W   = $clog2(RAS_DEPTH);
  localparam int unsigned       CNT_W   = $clog2(RAS_DEPTH + 1);
  localparam logic [ADDR_W-1:0] INC_V   = ADDR_W'(INC);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(RAS_DEPTH);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] seq_addr;
  logic [PTR_W-1:0]  top_q, top_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] stack_q [RAS_DEPTH];
  logic              ovf_q, ovf_d, unf_q, unf_d;
  logic              ovf_set, unf_set, push;
  logic              ras_empty, ras_full;

  assign seq_addr  = pc_q + INC_V;
  assign ras_empty = (cnt_q == '0);
  assign ras_full  = (cnt_q == CNT_MAX);

  always_comb begin
    pc_d    = pc_q;
    top_d   = top_q;
    cnt_d   = cnt_q;
    push    = 1'b0;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    if (pc_ld_en_i) begin
      if (ret_i) begin
        if (!ras_empty) begin
          pc_d  = stack_q[top_q];
          top_d = top_q - PTR_W'(1);
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          pc_d    = seq_addr;
          unf_set = 1'b1;
        end
      end else if (call_i) begin
        pc_d  = jump_addr_i;
        top_d = top_q + PTR_W'(1);
        push  = 1'b1;
        // When full, the push wraps onto the oldest entry and the count saturates.
        if (ras_full) ovf_set = 1'b1;
        else          cnt_d   = cnt_q + CNT_W'(1);
      end else if (jump_i) begin
        pc_d = jump_addr_i;
      end else if (branch_i) begin
        pc_d = pc_q + br_offset_i;
      end else begin
        pc_d = seq_addr;
      end
    end
    // A new event in the same cycle as a clear leaves the flag set.
    ovf_d = ovf_set | (ovf_q & ~flag_clr_i);
    unf_d = unf_set | (unf_q & ~flag_clr_i);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_q  <= RESET_VEC;
      top_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
      for (int i = 0; i < RAS_DEPTH; i++) stack_q[i] <= '0;
    end else begin
      pc_q  <= pc_d;
      top_q <= top_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
      if (push) stack_q[top_d] <= seq_addr;
    end
  end

  assign curr_addr_o = pc_q;
  assign seq_addr_o  = seq_addr;
  assign ras_empty_o = ras_empty;
  assign ras_full_o  = ras_full;
  assign ras_ovf_o   = ovf_q;
  assign ras_unf_o   = unf_q;

endmodule
